box_fill: RTL and testbench
===========================

# box_fill

Parametrised rectangle fill engine for the star-finding VGA pipeline. It writes a programmable colour to every pixel of an axis-aligned box in the framebuffer, or only to the box's one-pixel border. It is the general successor to the black-only box cleaner: it adds a write-ready stall handshake, one pixel per cycle throughput, invalid-box detection and an outline mode. It sits between the star-detection controller (which issues `go`) and the VGA adapter write port.

## Interface
Parameters:
- `X_SZ`, default 8: x coordinate width.
- `Y_SZ`, default 7: y coordinate width.
- `COL_SZ`, default 3: colour width.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `go`  in  1: start request; sampled only in IDLE.
- `x_left`, `x_right`  in  X_SZ: inclusive box column bounds.
- `y_top`, `y_bottom`  in  Y_SZ: inclusive box row bounds.
- `fill_col`  in  COL_SZ: colour to write.
- `mode`  in  1: 0 = solid fill, 1 = outline only.
- `wr_ready`  in  1: the VGA write port accepts the current pixel.
- `wr_en`  out  1: a pixel write is pending on `x_out`/`y_out`/`col_out`.
- `x_out`  out  X_SZ: pixel column.
- `y_out`  out  Y_SZ: pixel row.
- `col_out`  out  COL_SZ: pixel colour.
- `busy`  out  1: high from the start is accepted until the done cycle, inclusive.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle pulse, coincident with `done`, for an invalid box.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `go`=1 latches the four bounds, `fill_col` and `mode`.
  - `x` loads `x_left`; `y` loads `y_top`.
  - If `x_right<x_left` or `y_bottom<y_top`, go to DONE with an error flag set. Otherwise go to RUN.
- **RUN:**
  - `wr_en`=1, with `x_out`/`y_out`/`col_out` driven from the counters and latched colour.
  - Outputs hold stable until `wr_ready`=1. A pixel is transferred on a cycle where `wr_en` and `wr_ready` are both high.
  - Advance is raster order, decided by comparing before incrementing (no counter ever wraps, including `x_right`=2^X_SZ-1):
    - `x<x_right`: x advances.
    - Otherwise, if `y<y_bottom`: x reloads `x_left` and y increments.
    - Otherwise this was the last pixel: go to DONE.
- **Outline mode:**
  - Rows `y_top` and `y_bottom` are written in full.
  - Interior rows write only `x_left` then `x_right`: after `x_left`, x jumps straight to `x_right`.
  - If `x_left`=`x_right`, one pixel per row. No pixel is ever written twice.
- **DONE:**
  - `done`=1 for one cycle; `err`=1 in the same cycle if the box was invalid.
  - Then return to IDLE.
- **Other rules:**
  - `go` while not in IDLE is ignored. Inputs other than `go`/`wr_ready` are don't-care outside IDLE.
  - `reset` at any time: go to IDLE; all outputs 0 on the next cycle; no `done` for the aborted job.
- **Reset value of every output:** `wr_en`, `busy`, `done`, `err` = 0; `x_out`, `y_out`, `col_out` = 0.
  - In IDLE, `x_out`/`y_out`/`col_out` are held at 0.

## Timing
- `go` sampled at edge 0 → `busy`=`wr_en`=1 from cycle 1. The first pixel is `(x_left,y_top)`.
- With `wr_ready` held high, an N-pixel job writes on cycles 1..N and `done` is high on cycle N+1.
- Each cycle with `wr_ready`=0 adds exactly one cycle of latency.
- Invalid box: `done`=`err`=1 on cycle 1; `wr_en` is never asserted.
- A new `go` is accepted no earlier than the cycle after `done`.
- Pixel counts: solid = (W)(H); outline = 2W+2(H-2) for H≥2, W≥2. Here W = `x_right`-`x_left`+1 and H = `y_bottom`-`y_top`+1.

## Configuration
- `BOX_FILL_OUTLINE_EN`:
  - Defined: outline mode is implemented as described above.
  - Undefined: `mode` is ignored, every job is a solid fill, and the outline skip logic is not synthesised.

## Test plan
- Solid box (10,5)-(12,6), `fill_col`=3'b101, `wr_ready`=1:
  - writes (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on cycles 1-6, all `col_out`=101;
  - `done` pulse on cycle 7; `busy` low on cycle 8.
- Same box with `wr_ready` low on cycles 2-3:
  - (11,5) held for 3 cycles; `done` on cycle 9; no duplicate or skipped pixel.
- Outline (0,0)-(3,3) (requires `BOX_FILL_OUTLINE_EN`):
  - exactly 12 writes; interior (1..2,1..2) never written; `done` on cycle 13.
- Invalid box `x_left`=20, `x_right`=19:
  - `done`=`err`=1 on cycle 1; `wr_en` stays 0.
- Edge box (253,125)-(255,127):
  - 9 writes; x never exceeds 255, y never exceeds 127; no wrap to 0.
- `reset` asserted on cycle 3 of a 6-pixel job:
  - all outputs 0 from cycle 4; no `done`.
  - A `go` issued mid-job (without reset) is ignored and the job completes normally.

Source files
------------

// File: rtl/box_fill.sv
// box_fill: rectangle fill engine for the star-finding VGA pipeline.
// Writes fill_col to every pixel of an axis-aligned box (solid mode) or only
// to its one-pixel border (outline mode), one pixel per accepted cycle, in
// raster order, with a wr_ready stall handshake toward the VGA write port.
//
// Configuration macro: BOX_FILL_OUTLINE_EN
//   defined   - mode selects solid (0) or outline (1)
//   undefined - mode is ignored; every job is a solid fill
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   go                    start request, sampled only in IDLE
//   x_left, x_right       inclusive column bounds (X_SZ)
//   y_top, y_bottom       inclusive row bounds (Y_SZ)
//   fill_col              colour to write (COL_SZ)
//   mode                  0 = solid, 1 = outline
//   wr_ready              write port accepts the pending pixel
//   wr_en                 pixel write pending on x_out/y_out/col_out
//   x_out, y_out, col_out pixel coordinate and colour
//   busy                  high from start acceptance through the done cycle
//   done                  one-cycle completion pulse
//   err                   one-cycle invalid-box pulse, coincident with done
module box_fill #(
  parameter int unsigned X_SZ   = 8,
  parameter int unsigned Y_SZ   = 7,
  parameter int unsigned COL_SZ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [X_SZ-1:0]   x_left,
  input  logic [X_SZ-1:0]   x_right,
  input  logic [Y_SZ-1:0]   y_top,
  input  logic [Y_SZ-1:0]   y_bottom,
  input  logic [COL_SZ-1:0] fill_col,
  input  logic              mode,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [X_SZ-1:0]   x_out,
  output logic [Y_SZ-1:0]   y_out,
  output logic [COL_SZ-1:0] col_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Latched job bounds; x_out/y_out double as the raster counters.
  logic [X_SZ-1:0] xLeftQ;
  logic [X_SZ-1:0] xRightQ;
  logic [Y_SZ-1:0] yTopQ;
  logic [Y_SZ-1:0] yBottomQ;

  logic boxInvalid;
  logic colMore;
  logic rowMore;
  logic skipToRight;

  assign boxInvalid = (x_right < x_left) || (y_bottom < y_top);

  // Compare before incrementing so no counter ever wraps at the coordinate limit.
  assign colMore = (x_out < xRightQ);
  assign rowMore = (y_out < yBottomQ);

`ifdef BOX_FILL_OUTLINE_EN
  logic modeQ;

  // Interior rows of an outline only visit x_left and x_right.
  assign skipToRight = modeQ && (y_out != yTopQ) && (y_out != yBottomQ) &&
                       (x_out == xLeftQ);

  // Mode register, loaded alongside the other job parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      modeQ <= 1'b0;
    end else if (state == IDLE && go) begin
      modeQ <= mode;
    end
  end
`else
  logic unusedMode;

  assign unusedMode  = mode;
  assign skipToRight = 1'b0;
`endif

  // Job FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      xLeftQ   <= '0;
      xRightQ  <= '0;
      yTopQ    <= '0;
      yBottomQ <= '0;
      wr_en    <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      col_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (go) begin
            xLeftQ   <= x_left;
            xRightQ  <= x_right;
            yTopQ    <= y_top;
            yBottomQ <= y_bottom;
            busy     <= 1'b1;
            if (boxInvalid) begin
              // Nothing to draw: report straight away, pixel outputs stay 0.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= RUN;
              wr_en   <= 1'b1;
              x_out   <= x_left;
              y_out   <= y_top;
              col_out <= fill_col;
            end
          end
        end

        RUN: begin
          // Outputs hold until the write port takes the pixel.
          if (wr_ready) begin
            if (colMore) begin
              x_out <= skipToRight ? xRightQ : x_out + X_SZ'(1);
            end else if (rowMore) begin
              x_out <= xLeftQ;
              y_out <= y_out + Y_SZ'(1);
            end else begin
              state   <= DONE;
              wr_en   <= 1'b0;
              x_out   <= '0;
              y_out   <= '0;
              col_out <= '0;
              done    <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          wr_en   <= 1'b0;
          x_out   <= '0;
          y_out   <= '0;
          col_out <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_fill.sv
// tb_box_fill: randomized scoreboard bench for box_fill.
// The driver computes each job's pixel list from the box geometry and queues
// it; a negedge monitor pops and compares every accepted write and done pulse.
module tb_box_fill;

  localparam bit OUTLINE =
`ifdef BOX_FILL_OUTLINE_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] x_left;
  logic [7:0] x_right;
  logic [6:0] y_top;
  logic [6:0] y_bottom;
  logic [2:0] fill_col;
  logic       mode;
  logic       wr_ready;
  logic       wr_en;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] col_out;
  logic       busy;
  logic       done;
  logic       err;

  box_fill #(.X_SZ(8), .Y_SZ(7), .COL_SZ(3)) dut (
    .clk(clk), .reset(reset), .go(go),
    .x_left(x_left), .x_right(x_right), .y_top(y_top), .y_bottom(y_bottom),
    .fill_col(fill_col), .mode(mode), .wr_ready(wr_ready),
    .wr_en(wr_en), .x_out(x_out), .y_out(y_out), .col_out(col_out),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t pixQ[$];
  bit   doneQ[$];

  int   checks = 0;
  int   errors = 0;
  int   stallCnt = 0;
  bit   monEn = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every accepted pixel and every done pulse with the queues.
  bit          held = 0;
  logic [18:0] heldV;
  always @(negedge clk) begin
    if (monEn) begin
      if (held) begin
        checks++;
        if ({wr_en, x_out, y_out, col_out} !== heldV) begin
          errors++;
          $display("FAIL hold: got %h required %h", {wr_en, x_out, y_out, col_out}, heldV);
        end
        held = 0;
      end
      if (wr_en === 1'b1) begin
        if (wr_ready === 1'b1) begin
          checks++;
          if (pixQ.size() == 0) begin
            errors++;
            $display("FAIL extra_write: got (%0d,%0d,%0d) required no write", x_out, y_out, col_out);
          end else begin
            pix_t e;
            e = pixQ.pop_front();
            if ({x_out, y_out, col_out} !== e) begin
              errors++;
              $display("FAIL pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                       x_out, y_out, col_out, e.x, e.y, e.c);
            end
          end
        end else begin
          held  = 1;
          heldV = {wr_en, x_out, y_out, col_out};
          stallCnt++;
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (doneQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          bit eErr;
          eErr = doneQ.pop_front();
          if (err !== eErr) begin
            errors++;
            $display("FAIL err_flag: got %b required %b", err, eErr);
          end
          checks++;
          if (pixQ.size() != 0) begin
            errors++;
            $display("FAIL missing_pixels: got %0d unwritten required 0", pixQ.size());
            pixQ.delete();
          end
        end
      end else if (err !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL err_without_done: got err=%b required 0", err);
      end
      if (busy === 1'b0) begin
        checks++;
        if ({wr_en, x_out, y_out, col_out, done} !== 19'd0) begin
          errors++;
          $display("FAIL idle_outputs: got %h required 0", {wr_en, x_out, y_out, col_out, done});
        end
      end
    end
  end

  function automatic bit rdy(input int m, input int k);
    if (m == 0) return 1'b1;
    if (m == 1) return ($urandom % 3) != 0;
    return !(k == 2 || k == 3);
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic scramble();
    x_left   = 8'($urandom);
    x_right  = 8'($urandom);
    y_top    = 7'($urandom);
    y_bottom = 7'($urandom);
    fill_col = 3'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic runJob(input int xl, input int xr, input int yt, input int yb,
                        input int col, input bit md, input int rdyMode,
                        input int expDone, input bit goMid, input bit goInDone);
    int  n;
    int  cyc;
    bit  valid;
    bit  outl;
    bit  seen;
    waitIdle();
    valid = (xr >= xl) && (yb >= yt);
    outl  = OUTLINE && md;
    n = 0;
    if (valid) begin
      for (int y = yt; y <= yb; y++) begin
        for (int x = xl; x <= xr; x++) begin
          if (!outl || y == yt || y == yb || x == xl || x == xr) begin
            pixQ.push_back({8'(x), 7'(y), 3'(col)});
            n++;
          end
        end
      end
    end
    doneQ.push_back(!valid);

    @(posedge clk); #1;
    x_left = 8'(xl); x_right = 8'(xr); y_top = 7'(yt); y_bottom = 7'(yb);
    fill_col = 3'(col); mode = md; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    scramble();
    wr_ready = rdy(rdyMode, 1);
    stallCnt = 0;
    seen = 0;
    cyc = 0;
    for (int c = 1; c <= 4000; c++) begin
      cyc = c;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_start: got %b required 1", busy);
        end
        checks++;
        if (wr_en !== valid) begin
          errors++;
          $display("FAIL wr_en_start: got %b required %b", wr_en, valid);
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      if (goMid && c == 1) begin
        scramble();
        go = 1'b1;
      end else begin
        go = 1'b0;
      end
      wr_ready = rdy(rdyMode, c + 1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done required done after %0d pixels", n);
      pixQ.delete();
      doneQ.delete();
    end else begin
      checks++;
      if (cyc != n + 1 + stallCnt) begin
        errors++;
        $display("FAIL done_cycle: got %0d required %0d", cyc, n + 1 + stallCnt);
      end
      if (expDone >= 0) begin
        checks++;
        if (cyc != expDone) begin
          errors++;
          $display("FAIL done_cycle_fixed: got %0d required %0d", cyc, expDone);
        end
      end
      if (goInDone) go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL after_done: got busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  // Reset during cycle 3 of a six-pixel solid job.
  task automatic abortJob();
    waitIdle();
    for (int y = 5; y <= 6; y++)
      for (int x = 10; x <= 12; x++)
        pixQ.push_back({8'(x), 7'(y), 3'd6});
    @(posedge clk); #1;
    x_left = 8'd10; x_right = 8'd12; y_top = 7'd5; y_bottom = 7'd6;
    fill_col = 3'd6; mode = 1'b0; go = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_en, x_out, y_out, col_out, busy, done, err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {wr_en, x_out, y_out, col_out, busy, done, err});
    end
    checks++;
    if (pixQ.size() != 3) begin
      errors++;
      $display("FAIL reset_pixels_written: got %0d left required 3", pixQ.size());
    end
    pixQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xl, xr, yt, yb, w, h;
    reset = 1'b1; go = 1'b0; wr_ready = 1'b0;
    x_left = '0; x_right = '0; y_top = '0; y_bottom = '0; fill_col = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({wr_en, x_out, y_out, col_out, busy, done, err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0",
               {wr_en, x_out, y_out, col_out, busy, done, err});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    monEn = 1;

    runJob(10, 12, 5, 6, 5, 1'b0, 0, 7, 1'b0, 1'b1);
    runJob(10, 12, 5, 6, 5, 1'b0, 2, 9, 1'b1, 1'b0);
    runJob(0, 3, 0, 3, 2, 1'b1, 0, OUTLINE ? 13 : 17, 1'b0, 1'b0);
    runJob(20, 19, 10, 12, 1, 1'b0, 0, 1, 1'b0, 1'b0);
    runJob(10, 12, 9, 8, 1, 1'b1, 1, 1, 1'b0, 1'b0);
    runJob(253, 255, 125, 127, 7, 1'b0, 0, 10, 1'b0, 1'b0);
    runJob(253, 255, 125, 127, 4, 1'b1, 1, -1, 1'b0, 1'b0);
    runJob(40, 40, 3, 8, 3, 1'b1, 1, -1, 1'b0, 1'b0);
    runJob(0, 5, 0, 0, 6, 1'b1, 0, 7, 1'b0, 1'b0);
    abortJob();
    runJob(10, 12, 5, 6, 5, 1'b0, 0, 7, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      w  = $urandom_range(0, 5);
      h  = $urandom_range(0, 5);
      xl = ($urandom % 4 == 0) ? 255 - w : $urandom_range(0, 255 - w);
      yt = ($urandom % 4 == 0) ? 127 - h : $urandom_range(0, 127 - h);
      xr = xl + w;
      yb = yt + h;
      if ($urandom % 8 == 0 && xl > 0) xr = xl - 1;
      if ($urandom % 8 == 0 && yt > 0) yb = yt - 1;
      runJob(xl, xr, yt, yb, int'($urandom_range(0, 7)), 1'($urandom), 1, -1,
             1'($urandom), 1'($urandom));
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
